// File: rtl/even_odd.sv
// Tracks the parity of 0s and 1s seen on a serial bit stream since reset or clear.
// Moore output: out is the state register itself, {zeros_parity, ones_parity}.
//
// state | meaning
// S00   | even 0s, even 1s
// S10   | odd 0s,  even 1s
// S01   | even 0s, odd 1s
// S11   | odd 0s,  odd 1s
module even_odd (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] in,
    output logic [1:0] out
);

    localparam logic [1:0] S00 = 2'b00;
    localparam logic [1:0] S01 = 2'b01;
    localparam logic [1:0] S10 = 2'b10;
    localparam logic [1:0] S11 = 2'b11;

    logic [1:0] state;
    logic [1:0] state_next;

    always_comb begin
        state_next = state;
        if (in[1]) begin
            // Clear outranks the data bit on the same edge.
            state_next = S00;
        end else begin
            case (state)
                S00:     state_next = in[0] ? S01 : S10;
                S10:     state_next = in[0] ? S11 : S00;
                S01:     state_next = in[0] ? S00 : S11;
                S11:     state_next = in[0] ? S10 : S01;
                default: state_next = S00;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S00;
        end else begin
            state <= state_next;
        end
    end

    assign out = state;

endmodule

// File: tb/tb_even_odd.sv
// Self-checking bench for even_odd: directed sequences plus a random stream
// compared against a parity model through an expected-value queue.
module tb_even_odd;

    logic       clk;
    logic       rst;
    logic [1:0] in_s;
    logic [1:0] out_s;

    int total;
    int bad;

    logic [1:0] sb[$];
    logic       zp;
    logic       op;

    even_odd dut (
        .clk (clk),
        .rst (rst),
        .in  (in_s),
        .out (out_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    // Drive one input word, queue its expected result, then compare after the edge.
    task automatic step(input string tag, input logic [1:0] v, input logic [1:0] e);
        logic [1:0] exp;
        in_s = v;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, out_s, 2'bxx);
        end else begin
            exp = sb.pop_front();
            check(tag, out_s, exp);
        end
    endtask

    logic [7:0] ref_bits;
    logic [1:0] ref_exp[8];
    logic [1:0] cov_exp[4];
    logic [3:0] cov_bits;

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        in_s  = 2'b01;

        // Reset asserted between edges with the clock running.
        #2;
        rst = 1'b1;
        #1;
        check("rst_immediate", out_s, 2'b00);
        repeat (2) @(posedge clk);
        #1;
        check("rst_held", out_s, 2'b00);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("rst_release", out_s, 2'b00);
        step("first_edge", 2'b01, 2'b01);
        step("clear_a", 2'b10, 2'b00);

        // Reference sequence (in[0] listed first bit first).
        ref_bits = 8'b0110_0111;
        ref_exp[0] = 2'b10; ref_exp[1] = 2'b11; ref_exp[2] = 2'b10; ref_exp[3] = 2'b00;
        ref_exp[4] = 2'b10; ref_exp[5] = 2'b11; ref_exp[6] = 2'b10; ref_exp[7] = 2'b11;
        for (int i = 0; i < 8; i++) begin
            step($sformatf("ref_%0d", i), {1'b0, ref_bits[7-i]}, ref_exp[i]);
        end

        // Clear with data bit set, then full coverage from S00.
        step("clear_b", 2'b11, 2'b00);
        cov_bits = 4'b1010;
        cov_exp[0] = 2'b01; cov_exp[1] = 2'b11; cov_exp[2] = 2'b10; cov_exp[3] = 2'b00;
        for (int i = 0; i < 4; i++) begin
            step($sformatf("cov_%0d", i), {1'b0, cov_bits[3-i]}, cov_exp[i]);
        end

        // Clear priority from S11.
        step("to_s01", 2'b01, 2'b01);
        step("to_s11", 2'b00, 2'b11);
        step("clr_prio", 2'b11, 2'b00);
        step("after_clr", 2'b01, 2'b01);

        // Async reset mid-stream from S10.
        step("clear_c", 2'b10, 2'b00);
        step("to_s10", 2'b00, 2'b10);
        #3;
        rst = 1'b1;
        #1;
        check("mid_rst", out_s, 2'b00);
        #1;
        rst = 1'b0;
        #1;
        check("mid_rst_hold", out_s, 2'b00);
        step("after_rst", 2'b00, 2'b10);

        // Random stream against the parity model.
        step("clear_d", 2'b10, 2'b00);
        zp = 1'b0;
        op = 1'b0;
        for (int i = 0; i < 200; i++) begin
            logic b;
            b = 1'($urandom_range(0, 1));
            if (b) op = ~op;
            else   zp = ~zp;
            step($sformatf("rnd_%0d", i), {1'b0, b}, {zp, op});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
